// File: rtl/mac_result_drain_pkg.sv
// Shared types and helpers for the MAC result drain: FSM states, mode codes,
// lane-count and accumulator-width functions.
package mac_drain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_FLUSH0,
      ST_FLUSH1,
      ST_CAPTURE,
      ST_DRAIN
   } state_t;

   localparam logic [1:0] MODE_1X = 2'd0;
   localparam logic [1:0] MODE_2X = 2'd1;
   localparam logic [1:0] MODE_4X = 2'd3;

   function automatic logic [2:0] lane_count(input logic [1:0] mode);
      case (mode)
         MODE_2X: return 3'd2;
         MODE_4X: return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic mode_valid(input logic [1:0] mode);
      return (mode == MODE_1X) || (mode == MODE_2X) || (mode == MODE_4X);
   endfunction

   function automatic int z_width(input int w, input int a, input int p);
      return w + a + 4 * p;
   endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Beat-input and lane-output handshakes of the MAC result drain.
// valid/ready: a transfer happens on a rising edge where both are high; the
// producer holds valid and payload stable until that edge.
interface mac_result_drain_if #(
   parameter int Z_WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [Z_WIDTH-1:0] out_data;
   logic [1:0]         out_lane;
   logic               out_last;

   modport master (
      input  in_valid,
      output in_ready,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_lane,
      output out_last
   );

   modport slave (
      output in_valid,
      input  in_ready,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_lane,
      input  out_last
   );
endinterface

// File: rtl/mac_result_drain_lane_unpack.sv
// Combinational lane extraction from the guard-interleaved accumulator word.
// With MAC_DRAIN_GUARD_CHECK_EN defined it also reports the guard-bit mask.
module mac_lane_unpack import mac_drain_pkg::*; #(
   parameter int W_WIDTH    = 8,
   parameter int A_WIDTH    = 8,
   parameter int PLUS_WIDTH = 4,
   localparam int Z_WIDTH   = z_width(W_WIDTH, A_WIDTH, PLUS_WIDTH)
) (
   input  logic [Z_WIDTH-1:0] q,
   input  logic [1:0]         mode,
   input  logic [1:0]         lane,
`ifdef MAC_DRAIN_GUARD_CHECK_EN
   output logic [Z_WIDTH-1:0] guard_mask,
`endif
   output logic [Z_WIDTH-1:0] out_data
);

   // Each quarter holds D data bits with PLUS_WIDTH guard bits above them.
   localparam int D   = (W_WIDTH + A_WIDTH) / 4;
   localparam int QW  = D + PLUS_WIDTH;
   localparam int EX1 = Z_WIDTH - QW - 3 * D;
   localparam int EX2 = Z_WIDTH - QW - D;
   localparam int EX4 = Z_WIDTH - QW;

   logic [QW-1:0] qt [4];
   logic [D-1:0]  dt [4];

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         qt[k] = q[k*QW +: QW];
         dt[k] = q[k*QW +: D];
      end
   end

   always_comb begin
      out_data = '0;
      case (mode)
         MODE_4X: out_data = {{EX4{qt[lane][QW-1]}}, qt[lane]};
         MODE_2X: begin
            if (lane[0]) out_data = {{EX2{qt[3][QW-1]}}, qt[3], dt[2]};
            else         out_data = {{EX2{qt[1][QW-1]}}, qt[1], dt[0]};
         end
         default: out_data = {{EX1{qt[3][QW-1]}}, qt[3], dt[2], dt[1], dt[0]};
      endcase
   end

`ifdef MAC_DRAIN_GUARD_CHECK_EN
   always_comb begin
      guard_mask = '0;
      case (mode)
         MODE_1X: begin
            for (int k = 0; k < 3; k++) guard_mask[k*QW+D +: PLUS_WIDTH] = '1;
         end
         MODE_2X: begin
            guard_mask[D +: PLUS_WIDTH]        = '1;
            guard_mask[2*QW+D +: PLUS_WIDTH]   = '1;
         end
         default: guard_mask = '0;
      endcase
   end
`endif

endmodule

// File: rtl/mac_result_drain.sv
// Control-and-drain stage behind the multiplex MAC: clear, count beats, wait out
// the MAC pipeline, capture z and stream lanes. Optional MAC_DRAIN_GUARD_CHECK_EN.
module mac_result_drain import mac_drain_pkg::*; #(
   parameter int W_WIDTH         = 8,
   parameter int A_WIDTH         = 8,
   parameter int PLUS_WIDTH      = 4,
   parameter int CONFIG_AW_WIDTH = 2,
   parameter int LEN_WIDTH       = 8,
   localparam int Z_WIDTH        = z_width(W_WIDTH, A_WIDTH, PLUS_WIDTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [CONFIG_AW_WIDTH-1:0] config_aw,
   input  logic [LEN_WIDTH-1:0]       len,
   output logic [CONFIG_AW_WIDTH-1:0] cfg_out,
   output logic                       accu_rst,
   input  logic [Z_WIDTH-1:0]         z,
   output logic                       busy,
   output logic                       cfg_err,
   output logic                       guard_err,
   output state_t                     dbg_state,
   mac_result_drain_if.master         bus
);

   state_t                     state, state_next;
   logic [CONFIG_AW_WIDTH-1:0] cfg_q;
   logic [LEN_WIDTH-1:0]       len_q;
   logic [LEN_WIDTH-1:0]       beat_cnt;
   logic [1:0]                 lane_idx;
   logic [1:0]                 last_lane;
   logic [Z_WIDTH-1:0]         q;
   logic [Z_WIDTH-1:0]         lane_data;
   logic                       start_ok;
   logic                       beat_fire;
   logic                       last_beat;
   logic                       lane_fire;
   logic                       at_last_lane;

   assign start_ok     = start && mode_valid(config_aw);
   assign beat_fire    = (state == ST_ACCUM) && bus.in_valid;
   assign last_beat    = beat_cnt == len_q - LEN_WIDTH'(1);
   assign last_lane    = 2'(lane_count(cfg_q) - 3'd1);
   assign at_last_lane = lane_idx == last_lane;
   assign lane_fire    = (state == ST_DRAIN) && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (start_ok) state_next = ST_CLEAR;
         ST_CLEAR:   state_next = (len_q != '0) ? ST_ACCUM : ST_FLUSH0;
         ST_ACCUM:   if (beat_fire && last_beat) state_next = ST_FLUSH0;
         ST_FLUSH0:  state_next = ST_FLUSH1;
         ST_FLUSH1:  state_next = ST_CAPTURE;
         ST_CAPTURE: state_next = ST_DRAIN;
         ST_DRAIN:   if (lane_fire && at_last_lane) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_q    <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         lane_idx <= '0;
         q        <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= (state == ST_IDLE) && start && !mode_valid(config_aw);
         if ((state == ST_IDLE) && start_ok) begin
            cfg_q    <= config_aw;
            len_q    <= len;
            beat_cnt <= '0;
            lane_idx <= '0;
         end
         if (beat_fire) beat_cnt <= beat_cnt + LEN_WIDTH'(1);
         // Two flush cycles cover the MAC pipeline before z is sampled.
         if (state == ST_CAPTURE) q <= z;
         if (lane_fire) lane_idx <= at_last_lane ? 2'd0 : lane_idx + 2'd1;
      end
   end

`ifdef MAC_DRAIN_GUARD_CHECK_EN
   logic [Z_WIDTH-1:0] guard_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                             guard_err <= 1'b0;
      else if ((state == ST_CAPTURE) && |(z & guard_mask)) guard_err <= 1'b1;
   end
`else
   assign guard_err = 1'b0;
`endif

   mac_lane_unpack #(
      .W_WIDTH    (W_WIDTH),
      .A_WIDTH    (A_WIDTH),
      .PLUS_WIDTH (PLUS_WIDTH)
   ) u_unpack (
      .q          (q),
      .mode       (cfg_q),
      .lane       (lane_idx),
`ifdef MAC_DRAIN_GUARD_CHECK_EN
      .guard_mask (guard_mask),
`endif
      .out_data   (lane_data)
   );

   assign busy          = state != ST_IDLE;
   assign accu_rst      = state == ST_CLEAR;
   assign cfg_out       = cfg_q;
   assign dbg_state     = state;
   assign bus.in_ready  = state == ST_ACCUM;
   assign bus.out_valid = state == ST_DRAIN;
   assign bus.out_data  = lane_data;
   assign bus.out_lane  = lane_idx;
   assign bus.out_last  = (state == ST_DRAIN) && at_last_lane;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain with a minimal two-stage MAC stand-in
// that adds a hand-packed per-beat contribution into z.
module tb_mac_result_drain;
   import mac_drain_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  config_aw;
   logic [7:0]  len;
   logic [1:0]  cfg_out;
   logic        accu_rst;
   logic [31:0] z;
   logic        busy;
   logic        cfg_err;
   logic        guard_err;
   state_t      dbg_state;

   logic [31:0] contrib;
   logic [31:0] d1, d2, acc;
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n;

   mac_result_drain_if #(.Z_WIDTH(32)) bus ();

   mac_result_drain dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .config_aw (config_aw),
      .len       (len),
      .cfg_out   (cfg_out),
      .accu_rst  (accu_rst),
      .z         (z),
      .busy      (busy),
      .cfg_err   (cfg_err),
      .guard_err (guard_err),
      .dbg_state (dbg_state),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // MAC stand-in: a beat accepted at edge k is in z from edge k+2.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= '0; d2 <= '0; acc <= '0;
      end else begin
         d1  <= (bus.in_valid && bus.in_ready) ? contrib : 32'h0;
         d2  <= d1;
         acc <= accu_rst ? 32'h0 : acc + d2;
      end
   end
   assign z = acc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [1:0] c, input logic [7:0] l);
      start = 1'b1; config_aw = c; len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_beats(input int cnt_req);
      int cnt = 0;
      int g = 0;
      bus.in_valid = 1'b1;
      while (cnt < cnt_req && g < 50) begin
         if (bus.in_ready) cnt++;
         g++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("beats_accepted", cnt, cnt_req);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic drain(input int lanes, input int stall_lane);
      logic [31:0] e;
      for (int i = 0; i < lanes; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         chk("out_valid", bus.out_valid, 1);
         chk("out_lane", bus.out_lane, i);
         chk("out_last", bus.out_last, (i == lanes - 1) ? 1 : 0);
         chk("out_data", bus.out_data, e);
         if (i == stall_lane) begin
            bus.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("hold_valid", bus.out_valid, 1);
               chk("hold_lane", bus.out_lane, i);
               chk("hold_data", bus.out_data, e);
            end
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
      chk("busy_after_drain", busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; config_aw = 2'd0; len = 8'd0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; contrib = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_accu_rst", accu_rst, 0);
      chk("rst_cfg_out", cfg_out, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_guard_err", guard_err, 0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      @(negedge clk);

      // Mode 4x, two beats of a=w=0x55: each 2-bit lane product 1, summed twice.
      do_start(2'd3, 8'd2);
      chk("a_busy", busy, 1);
      chk("a_accu_rst", accu_rst, 1);
      chk("a_cfg_out", cfg_out, 3);
      chk("a_in_ready_clear", bus.in_ready, 0);
      contrib = 32'h0101_0101;
      send_beats(2);
      chk("a_in_ready_after", bus.in_ready, 0);
      wait_valid(n);
      chk("a_latency", n, 3);
      repeat (4) exp_q.push_back(32'h0000_0002);
      drain(4, -1);

      // Mode 1x, a=0xFF w=0x80: -32640; a start while busy must be ignored.
      do_start(2'd0, 8'd1);
      contrib = 32'hF800_0800;
      send_beats(1);
      start = 1'b1; config_aw = 2'd3; len = 8'd5;
      @(negedge clk);
      start = 1'b0;
      chk("b_cfg_kept", cfg_out, 0);
      chk("b_busy", busy, 1);
      wait_valid(n);
      chk("b_latency", n, 2);
      exp_q.push_back(32'hFFFF_8080);
      drain(1, -1);
      chk("b_guard_err", guard_err, 0);

      // Mode 2x, a=0x21 w=0xF1: lane0 = 1*1, lane1 = 2*(-1); stall on lane 1.
      do_start(2'd1, 8'd1);
      contrib = 32'hFF0E_0001;
      send_beats(1);
      wait_valid(n);
      chk("c_latency", n, 3);
      exp_q.push_back(32'h0000_0001);
      exp_q.push_back(32'hFFFF_FFFE);
      drain(2, 1);

      // len 0 in mode 4x: four zero lanes from s+4, stall on lane 0.
      do_start(2'd3, 8'd0);
      chk("d_accu_rst", accu_rst, 1);
      wait_valid(n);
      chk("d_latency", n, 4);
      repeat (4) exp_q.push_back(32'h0);
      drain(4, 0);

      // Reset in ACCUM after 1 of 4 beats, then a clean run.
      do_start(2'd3, 8'd4);
      contrib = 32'h0101_0101;
      send_beats(1);
      chk("e_in_accum", 32'(dbg_state), 32'(ST_ACCUM));
      rst = 1'b1;
      #1;
      chk("e_busy", busy, 0);
      chk("e_in_ready", bus.in_ready, 0);
      chk("e_out_valid", bus.out_valid, 0);
      chk("e_cfg_out", cfg_out, 0);
      chk("e_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_start(2'd1, 8'd1);
      contrib = 32'hFF0E_0001;
      send_beats(1);
      wait_valid(n);
      chk("e2_latency", n, 3);
      exp_q.push_back(32'h0000_0001);
      exp_q.push_back(32'hFFFF_FFFE);
      drain(2, -1);

      // Illegal mode 2 at start.
      do_start(2'd2, 8'd3);
      chk("f_cfg_err", cfg_err, 1);
      chk("f_busy", busy, 0);
      @(negedge clk);
      chk("f_cfg_err_pulse", cfg_err, 0);
      chk("f_busy2", busy, 0);
      chk("f_cfg_kept", cfg_out, 1);

      // Nonzero guard nibble z[23:20] in mode 1x.
      do_start(2'd0, 8'd1);
      contrib = 32'h0010_0000;
      send_beats(1);
      wait_valid(n);
      chk("g_latency", n, 3);
      exp_q.push_back(32'h0);
      drain(1, -1);
      repeat (2) @(negedge clk);
`ifdef MAC_DRAIN_GUARD_CHECK_EN
      chk("g_guard_err", guard_err, 1);
`else
      chk("g_guard_err", guard_err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
